// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK excitation driver: state encoding, counter widths
// and the per-bit JK excitation rule.
package jk_drv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRIVE  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_CHECK  = 2'd3;

  // Wide enough for SETTLE_CYC up to 15 and MAX_RETRY up to 7.
  localparam int SETTLE_CNT_W = 4;
  localparam int RETRY_CNT_W  = 3;

  // Returns {j,k} that moves one flop from q to t; dc fills the don't-care term.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
    logic [1:0] jk;
    case ({q, t})
      2'b00:   jk = {1'b0, dc};
      2'b01:   jk = {1'b1, dc};
      2'b10:   jk = {dc, 1'b1};
      default: jk = {dc, 1'b0};
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_bank.sv
// Combinational W-bit JK excitation generator: j/k that carry q_i to target_i in one edge.
module jk_excite_bank
  import jk_drv_pkg::*;
#(
  parameter int   W  = 4,
  parameter logic DC = 1'b0
) (
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] j_o,
  output logic [W-1:0] k_o
);

  always_comb begin
    j_o = '0;
    k_o = '0;
    for (int i = 0; i < W; i++) begin
      {j_o[i], k_o[i]} = jk_excite(q_i[i], target_i[i], DC);
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop bank to a requested value with drive/settle/check and bounded retry.
// Optional JK_DRV_STATS_EN adds saturating retry_total/req_total counters.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int W          = 4,
  parameter int SETTLE_CYC = 0,
  parameter int MAX_RETRY  = 2,
  parameter int DC_TOGGLE  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_target,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  input  logic [W-1:0] q_fb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         err_flag
`ifdef JK_DRV_STATS_EN
  ,
  output logic [15:0]  retry_total,
  output logic [15:0]  req_total
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
      (SETTLE_CYC > 0) ? SETTLE_CNT_W'(SETTLE_CYC - 1) : '0;
  localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRY);

  state_t                  state_q,  state_d;
  logic [W-1:0]            target_q, target_d;
  logic [W-1:0]            j_q, j_d, k_q, k_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    eflag_q, eflag_d;
  logic [RETRY_CNT_W-1:0]  retry_q, retry_d;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;

  logic [W-1:0] exc_t, exc_j, exc_k;
  logic         accept, match, redrive;

  // In IDLE the excitation must come from the incoming target, since it is registered at accept.
  assign exc_t   = (state_q == ST_IDLE) ? req_target : target_q;
  assign accept  = (state_q == ST_IDLE) && req_valid && ready_q;
  assign match   = (q_fb == target_q);
  assign redrive = (state_q == ST_CHECK) && !match && (retry_q < RETRY_MAX);

  jk_excite_bank #(
    .W  (W),
    .DC ((DC_TOGGLE != 0) ? 1'b1 : 1'b0)
  ) u_bank (
    .q_i      (q_fb),
    .target_i (exc_t),
    .j_o      (exc_j),
    .k_o      (exc_k)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    j_d      = '0;
    k_d      = '0;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    eflag_d  = eflag_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          target_d = req_target;
          retry_d  = '0;
          eflag_d  = 1'b0;
          j_d      = exc_j;
          k_d      = exc_k;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        settle_d = '0;
        state_d  = (SETTLE_CYC > 0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
        else                         settle_d = settle_q + SETTLE_CNT_W'(1);
      end
      default: begin
        if (match) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (redrive) begin
          retry_d = retry_q + RETRY_CNT_W'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = ST_DRIVE;
        end else begin
          err_d   = 1'b1;
          eflag_d = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      eflag_q  <= 1'b0;
      retry_q  <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      eflag_q  <= eflag_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_flag  = eflag_q;

`ifdef JK_DRV_STATS_EN
  logic [15:0] retry_tot_q, req_tot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_tot_q <= '0;
      req_tot_q   <= '0;
    end else begin
      if (redrive && (retry_tot_q != 16'hFFFF)) retry_tot_q <= retry_tot_q + 16'd1;
      if (accept && (req_tot_q != 16'hFFFF))    req_tot_q   <= req_tot_q + 16'd1;
    end
  end

  assign retry_total = retry_tot_q;
  assign req_total   = req_tot_q;
`endif

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: two driver instances (plain set/reset and toggle+settle), each closing the loop
// through a behavioural JK flop bank with an optional stuck-at-0 mask.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       va, vb;
  logic [3:0] tgt_a, tgt_b;
  logic       rdy_a, rdy_b, busy_a, busy_b, done_a, done_b, err_a, err_b, ef_a, ef_b;
  logic [3:0] ja, ka, jb, kb;
  logic [3:0] qa, qb;
  logic       ld_a, ld_b;
  logic [3:0] ld_val_a, ld_val_b, stk_a;
`ifdef JK_DRV_STATS_EN
  logic [15:0] rt_a, rq_a, rt_b, rq_b;
`endif

  jk_excitation_driver #(.W(4), .SETTLE_CYC(0), .MAX_RETRY(2), .DC_TOGGLE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(rdy_a), .req_target(tgt_a),
    .j(ja), .k(ka), .q_fb(qa), .busy(busy_a), .done(done_a), .err(err_a), .err_flag(ef_a)
`ifdef JK_DRV_STATS_EN
    , .retry_total(rt_a), .req_total(rq_a)
`endif
  );

  jk_excitation_driver #(.W(4), .SETTLE_CYC(3), .MAX_RETRY(2), .DC_TOGGLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(rdy_b), .req_target(tgt_b),
    .j(jb), .k(kb), .q_fb(qb), .busy(busy_b), .done(done_b), .err(err_b), .err_flag(ef_b)
`ifdef JK_DRV_STATS_EN
    , .retry_total(rt_b), .req_total(rq_b)
`endif
  );

  // Behavioural JK flops: Q+ = J&~Q | ~K&Q, stuck bits forced to 0.
  always @(posedge clk) begin
    if (ld_a) qa <= ld_val_a & ~stk_a;
    else      qa <= ((ja & ~qa) | (~ka & qa)) & ~stk_a;
    if (ld_b) qb <= ld_val_b;
    else      qb <= (jb & ~qb) | (~kb & qb);
  end

  logic       sel;
  logic [3:0] oj, ok, oq;
  logic       ordy, obusy, odone, oerr, oef;
  assign oj    = sel ? jb : ja;
  assign ok    = sel ? kb : ka;
  assign oq    = sel ? qb : qa;
  assign ordy  = sel ? rdy_b : rdy_a;
  assign obusy = sel ? busy_b : busy_a;
  assign odone = sel ? done_b : done_a;
  assign oerr  = sel ? err_b : err_a;
  assign oef   = sel ? ef_b : ef_a;

  int n_chk = 0;
  int n_pass = 0;
  int acc_a = 0, acc_b = 0, red_a = 0, red_b = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Excitation from the truth table: hold bits use the non-toggling half, changing bits use dc.
  function automatic logic [7:0] exp_jk(input logic [3:0] q, input logic [3:0] t, input logic dc);
    logic [3:0] jj, kk;
    for (int i = 0; i < 4; i++) begin
      if (q[i] == t[i]) begin
        jj[i] = q[i] ? dc : 1'b0;
        kk[i] = q[i] ? 1'b0 : dc;
      end else begin
        jj[i] = t[i] ? 1'b1 : dc;
        kk[i] = t[i] ? dc : 1'b1;
      end
    end
    return {jj, kk};
  endfunction

  task automatic load(input bit b, input logic [3:0] val);
    @(negedge clk);
    if (b) begin ld_b = 1'b1; ld_val_b = val; end
    else   begin ld_a = 1'b1; ld_val_a = val; end
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  // One request from accept to done/err, checked cycle by cycle against the flop model.
  task automatic txn(input bit b, input logic [3:0] t, input bit keep, input logic [3:0] t2);
    int n, att, settle;
    bit fin;
    logic [3:0] qc;
    sel    = b;
    settle = b ? 3 : 0;
    n      = 0;
    #1;
    while (!ordy && n < 60) begin @(negedge clk); n++; end
    chk("ready_wait", {7'd0, ordy}, 8'd1);
    if (b) begin vb = 1'b1; tgt_b = t; end
    else   begin va = 1'b1; tgt_a = t; end
    qc = oq;
    @(negedge clk);
    if (keep) begin
      if (b) tgt_b = t2; else tgt_a = t2;
    end else begin
      va = 1'b0;
      vb = 1'b0;
    end
    if (b) acc_b++; else acc_a++;
    chk("accept_busy_rdy", {6'd0, obusy, ordy}, 8'b10);
    chk("accept_eflag_clr", {7'd0, oef}, 8'd0);
    fin = 1'b0;
    att = 0;
    while (!fin) begin
      chk("drive_done_err", {6'd0, odone, oerr}, 8'd0);
      chk("drive_jk", {oj, ok}, exp_jk(qc, t, b));
      repeat (settle + 1) begin
        @(negedge clk);
        chk("quiet_jk", {oj, ok}, 8'd0);
        chk("quiet_busy_done", {5'd0, obusy, odone, oerr}, 8'b100);
      end
      qc = oq;
      @(negedge clk);
      if (qc == t) begin
        chk("done_pulse", {6'd0, odone, oerr}, 8'b10);
        chk("done_rdy_busy_ef", {5'd0, ordy, obusy, oef}, 8'b100);
        fin = 1'b1;
      end else if (att < 2) begin
        att++;
        if (b) red_b++; else red_a++;
        chk("retry_busy", {7'd0, obusy}, 8'd1);
      end else begin
        chk("err_pulse", {6'd0, odone, oerr}, 8'b01);
        chk("err_rdy_busy_ef", {5'd0, ordy, obusy, oef}, 8'b101);
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    logic [3:0] t, q, s;
    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; tgt_a = '0; tgt_b = '0;
    ld_a = 1'b1; ld_b = 1'b1; ld_val_a = '0; ld_val_b = '0; stk_a = '0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
    chk("rst_a_jk", {ja, ka}, 8'd0);
    chk("rst_b_jk", {jb, kb}, 8'd0);
    chk("rst_a_flags", {3'd0, rdy_a, busy_a, done_a, err_a, ef_a}, 8'd0);
    chk("rst_b_flags", {3'd0, rdy_b, busy_b, done_b, err_b, ef_b}, 8'd0);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", {6'd0, rdy_a, rdy_b}, 8'd0);
    @(negedge clk);
    chk("rdy_after_edge", {6'd0, rdy_a, rdy_b}, 8'b11);

    // Plain set on A, then the DC_TOGGLE example on B.
    txn(1'b0, 4'b1010, 1'b0, 4'd0);
    load(1'b1, 4'b1100);
    txn(1'b1, 4'b0110, 1'b0, 4'd0);

    // Target equal to current Q still drives once with hold-type j/k.
    load(1'b0, 4'b0110);
    txn(1'b0, 4'b0110, 1'b0, 4'd0);
    txn(1'b1, 4'b0110, 1'b0, 4'd0);

    // Stuck bit0: three drives then err; flag sticks until the next accept clears it.
    load(1'b0, 4'b0000);
    stk_a = 4'b0001;
    txn(1'b0, 4'b0001, 1'b0, 4'd0);
    @(negedge clk);
    sel = 1'b0;
    #1 chk("eflag_sticky", {7'd0, ef_a}, 8'd1);
    stk_a = 4'b0000;
    txn(1'b0, 4'b1000, 1'b0, 4'd0);

    // Held req_valid with a changing target: only the accepted value counts.
    txn(1'b0, 4'b0011, 1'b1, 4'b1100);
    txn(1'b0, 4'b1100, 1'b0, 4'd0);

    // Reset during DRIVE.
    load(1'b0, 4'b0000);
    va = 1'b1; tgt_a = 4'b0101;
    @(negedge clk);
    va = 1'b0;
    chk("pre_rst_j", {ja, ka}, {4'b0101, 4'b0000});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_jk", {ja, ka}, 8'd0);
    chk("mid_rst_flags", {3'd0, rdy_a, busy_a, done_a, err_a, ef_a}, 8'd0);
    @(negedge clk);
    chk("rst_hold_nopulse", {6'd0, done_a, err_a}, 8'd0);
    chk("rst_q_held", {4'd0, qa}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {6'd0, rdy_a, busy_a}, 8'b10);
    acc_a = 0; acc_b = 0; red_a = 0; red_b = 0;

    // Randomized traffic on both instances, with occasional stuck masks on A.
    for (int i = 0; i < 16; i++) begin
      q = 4'($urandom_range(0, 15));
      t = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      stk_a = s;
      load(1'b0, q);
      txn(1'b0, t, 1'b0, 4'd0);
    end
    stk_a = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      q = 4'($urandom_range(0, 15));
      t = 4'($urandom_range(0, 15));
      load(1'b1, q);
      txn(1'b1, t, 1'b0, 4'd0);
    end
    @(negedge clk);
    chk("final_quiet_a", {3'd0, busy_a, done_a, err_a, 2'd0}, 8'd0);

`ifdef JK_DRV_STATS_EN
    chk("req_total_a", rq_a[7:0], 8'(acc_a));
    chk("req_total_b", rq_b[7:0], 8'(acc_b));
    chk("retry_total_a", rt_a[7:0], 8'(red_a));
    chk("retry_total_b", rt_b[7:0], 8'(red_b));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
